// File: rtl/fu_sched.sv
// fu_sched: round-robin scheduler sharing one fu (16-bit ALU) among four
// requesters. Grants at most one operation per cycle into registered fu
// inputs. A tag pipeline matched to FU_LAT returns each result with its
// requester ID on a shared response port.
// Optional build macro: FU_SCHED_PRIO_EN gives requester 0 fixed top priority.
// With this macro, requesters 1..3 round-robin among themselves.
module fu_sched #(
  parameter int unsigned DSIZE  = 16,
  parameter int unsigned OPSIZE = 5,
  parameter int unsigned FU_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sched_en,
  input  logic [3:0]          req_valid,
  input  logic [4*OPSIZE-1:0] req_op,
  input  logic [4*DSIZE-1:0]  req_a,
  input  logic [4*DSIZE-1:0]  req_b,
  output logic [3:0]          req_ready,
  output logic [OPSIZE-1:0]   fu_op,
  output logic [DSIZE-1:0]    fu_a,
  output logic [DSIZE-1:0]    fu_b,
  input  logic [DSIZE-1:0]    fu_f,
  input  logic                fu_z,
  input  logic                fu_n,
  input  logic                fu_c,
  input  logic                fu_v,
  output logic                rsp_valid,
  output logic [1:0]          rsp_id,
  output logic [DSIZE-1:0]    rsp_f,
  output logic [3:0]          rsp_flags,
  output logic                idle
);

  logic [1:0]            last;
  logic [3:0]            rr_valid;
  logic [1:0]            grant_id;
  logic [1:0]            idx;
  logic                  found;
  logic                  hs;
  logic [FU_LAT:0]       tag_vld;
  logic [FU_LAT:0][1:0]  tag_id;

  // Arbitration: search starts at last+1 and wraps. The optional mode pre-empts with requester 0.
  always_comb begin
    rr_valid = req_valid;
    grant_id = '0;
    idx      = '0;
    found    = 1'b0;
`ifdef FU_SCHED_PRIO_EN
    rr_valid[0] = 1'b0;
`endif
    if (sched_en) begin
`ifdef FU_SCHED_PRIO_EN
      if (req_valid[0]) begin
        grant_id = 2'd0;
        found    = 1'b1;
      end
`endif
      for (int unsigned k = 1; k <= 4; k++) begin
        idx = last + 2'(k);
        if (!found && rr_valid[idx]) begin
          grant_id = idx;
          found    = 1'b1;
        end
      end
    end
  end

  // Grant is forced low while reset is asserted so outputs reset immediately
  always_comb begin
    hs        = found & rst_n;
    req_ready = hs ? (4'b0001 << grant_id) : '0;
  end

  // Last-grant pointer; the optional mode tracks only grants to requesters 1..3
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 2'd3;
    end else if (hs) begin
`ifdef FU_SCHED_PRIO_EN
      if (grant_id != 2'd0) last <= grant_id;
`else
      last <= grant_id;
`endif
    end
  end

  // Registered fu inputs load the granted requester's fields and hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fu_op <= '0;
      fu_a  <= '0;
      fu_b  <= '0;
    end else if (hs) begin
      fu_op <= req_op[grant_id*OPSIZE +: OPSIZE];
      fu_a  <= req_a[grant_id*DSIZE +: DSIZE];
      fu_b  <= req_b[grant_id*DSIZE +: DSIZE];
    end
  end

  // Tag pipeline: FU_LAT+1 stages of {vld, id}, shifting every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld <= {tag_vld[FU_LAT-1:0], hs};
      tag_id  <= {tag_id[FU_LAT-1:0], grant_id};
    end
  end

  // Response register: capture fu result and flags when the final tag stage is valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_f     <= '0;
      rsp_flags <= '0;
    end else begin
      rsp_valid <= tag_vld[FU_LAT];
      if (tag_vld[FU_LAT]) begin
        rsp_id    <= tag_id[FU_LAT];
        rsp_f     <= fu_f;
        rsp_flags <= {fu_z, fu_n, fu_c, fu_v};
      end
    end
  end

  // Idle when nothing is in flight and no response is being presented
  always_comb begin
    idle = ~(|tag_vld | rsp_valid);
  end

endmodule

// File: tb/tb_fu_sched.sv
// Testbench for fu_sched. A registered ALU stub (FU_LAT=1) stands in for fu.
// A table of per-cycle grant vectors is applied. A scoreboard checks every
// response for ID, value, flags and arrival cycle. Directed sequences cover
// drain, idle timing and reset mid-flight.
module tb_fu_sched;

  localparam int unsigned DSIZE  = 16;
  localparam int unsigned OPSIZE = 5;
  localparam int unsigned FU_LAT = 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                sched_en;
  logic [3:0]          req_valid;
  logic [4*OPSIZE-1:0] req_op;
  logic [4*DSIZE-1:0]  req_a;
  logic [4*DSIZE-1:0]  req_b;
  logic [3:0]          req_ready;
  logic [OPSIZE-1:0]   fu_op;
  logic [DSIZE-1:0]    fu_a;
  logic [DSIZE-1:0]    fu_b;
  logic [DSIZE-1:0]    fu_f;
  logic                fu_z, fu_n, fu_c, fu_v;
  logic                rsp_valid;
  logic [1:0]          rsp_id;
  logic [DSIZE-1:0]    rsp_f;
  logic [3:0]          rsp_flags;
  logic                idle;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fu_sched #(.DSIZE(DSIZE), .OPSIZE(OPSIZE), .FU_LAT(FU_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .sched_en(sched_en),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .fu_op(fu_op), .fu_a(fu_a), .fu_b(fu_b),
    .fu_f(fu_f), .fu_z(fu_z), .fu_n(fu_n), .fu_c(fu_c), .fu_v(fu_v),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_f(rsp_f),
    .rsp_flags(rsp_flags), .idle(idle)
  );

  // ALU model: returns {F, Z, N, C, V}
  function automatic logic [19:0] alu(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] w;
    logic [15:0] r;
    logic        c, v;
    w = '0; c = 1'b0; v = 1'b0;
    case (op)
      5'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[15:0]; c = w[16];
                  v = (a[15] == b[15]) && (r[15] != a[15]); end
      5'd1: begin r = a - b; c = (a < b);
                  v = (a[15] != b[15]) && (r[15] != a[15]); end
      5'd2: r = a & b;
      5'd3: r = a ^ b;
      default: r = a | b;
    endcase
    return {r, (r == 16'h0000), r[15], c, v};
  endfunction

  // fu stub with one edge of latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {fu_f, fu_z, fu_n, fu_c, fu_v} <= '0;
    else        {fu_f, fu_z, fu_n, fu_c, fu_v} <= alu(fu_op, fu_a, fu_b);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard
  typedef struct {
    logic [1:0]  id;
    logic [15:0] f;
    logic [3:0]  fl;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;

  // Push an expectation for every handshake seen at a rising edge
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_t e;
          logic [19:0] r;
          r = alu(req_op[i*OPSIZE +: OPSIZE], req_a[i*DSIZE +: DSIZE], req_b[i*DSIZE +: DSIZE]);
          e.id = 2'(i); e.f = r[19:4]; e.fl = r[3:0]; e.due = cyc + FU_LAT + 1;
          sb.push_back(e);
        end
      end
    end
  end

  // Pop and compare responses on the falling edge
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: got rsp_valid=1 id=%0d expected no response", rsp_id);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_f", 32'(rsp_f), 32'(e.f));
          chk("rsp_flags", 32'(rsp_flags), 32'(e.fl));
          chk("rsp_cycle", cyc, e.due);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        checks++; errors++;
        $display("FAIL rsp_missing: got no response expected id=%0d at cycle %0d", sb[0].id, sb[0].due);
        void'(sb.pop_front());
      end
    end
  end

  // Driver state: requesters keep fields stable while waiting
  logic [3:0] last_gnt;
  logic [3:0] prev_v;

  task automatic step(input logic en, input logic [3:0] v, input logic [3:0] exp_rdy,
                      input string name, input bit rnd);
    sched_en  = en;
    req_valid = v;
    if (rnd) begin
      for (int i = 0; i < 4; i++) begin
        if (!(prev_v[i] && !last_gnt[i])) begin
          req_op[i*OPSIZE +: OPSIZE] = 5'($urandom_range(0, 4));
          req_a[i*DSIZE +: DSIZE]    = 16'($urandom);
          req_b[i*DSIZE +: DSIZE]    = 16'($urandom);
        end
      end
    end
    #1;
    chk(name, 32'(req_ready), 32'(exp_rdy));
    last_gnt = req_ready;
    prev_v   = v;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    last_gnt = '0; prev_v = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       en;
    logic [3:0] v;
    logic [3:0] rr;
    logic [3:0] pr;
  } vec_t;

  vec_t tbl[20];

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1, 4'b0100, 4'b0100, 4'b0100};
    tbl[1]  = '{1'b1, 4'b1111, 4'b1000, 4'b0001};
    tbl[2]  = '{1'b1, 4'b1111, 4'b0001, 4'b0001};
    tbl[3]  = '{1'b1, 4'b1111, 4'b0010, 4'b0001};
    tbl[4]  = '{1'b1, 4'b1111, 4'b0100, 4'b0001};
    tbl[5]  = '{1'b1, 4'b1111, 4'b1000, 4'b0001};
    tbl[6]  = '{1'b1, 4'b1111, 4'b0001, 4'b0001};
    tbl[7]  = '{1'b1, 4'b1111, 4'b0010, 4'b0001};
    tbl[8]  = '{1'b1, 4'b1111, 4'b0100, 4'b0001};
    tbl[9]  = '{1'b1, 4'b0011, 4'b0001, 4'b0001};
    tbl[10] = '{1'b1, 4'b0011, 4'b0010, 4'b0001};
    tbl[11] = '{1'b1, 4'b0000, 4'b0000, 4'b0000};
    tbl[12] = '{1'b0, 4'b1111, 4'b0000, 4'b0000};
    tbl[13] = '{1'b1, 4'b1001, 4'b1000, 4'b0001};
    tbl[14] = '{1'b1, 4'b1001, 4'b0001, 4'b0001};
    tbl[15] = '{1'b1, 4'b0000, 4'b0000, 4'b0000};
    tbl[16] = '{1'b1, 4'b1110, 4'b0010, 4'b1000};
    tbl[17] = '{1'b1, 4'b1110, 4'b0100, 4'b0010};
    tbl[18] = '{1'b1, 4'b0011, 4'b0001, 4'b0001};
    tbl[19] = '{1'b1, 4'b0010, 4'b0010, 4'b0010};

    rst_n = 1'b0; sched_en = 1'b1; req_valid = 4'b1111;
    req_op = '0; req_a = '0; req_b = '0;
    last_gnt = '0; prev_v = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    chk("reset_fu_op", 32'(fu_op), 32'h0);
    chk("reset_fu_a", 32'(fu_a), 32'h0);
    chk("reset_fu_b", 32'(fu_b), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_id", 32'(rsp_id), 32'h0);
    chk("reset_rsp_f", 32'(rsp_f), 32'h0);
    chk("reset_rsp_flags", 32'(rsp_flags), 32'h0);
    chk("reset_idle", 32'(idle), 32'h1);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single request from requester 2: 3 + 4
    req_op[2*OPSIZE +: OPSIZE] = 5'd0;
    req_a[2*DSIZE +: DSIZE] = 16'h0003;
    req_b[2*DSIZE +: DSIZE] = 16'h0004;
    step(1'b1, 4'b0100, 4'b0100, "single_grant", 1'b0);
    chk("single_busy", 32'(idle), 32'h0);
    step(1'b1, 4'b0000, 4'b0000, "single_nogrant", 1'b1);
    chk("single_not_yet", 32'(rsp_valid), 32'h0);
    step(1'b1, 4'b0000, 4'b0000, "single_nogrant", 1'b1);
    #1;
    chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("single_rsp_id", 32'(rsp_id), 32'h2);
    chk("single_rsp_f", 32'(rsp_f), 32'h0007);
    chk("single_rsp_flags", 32'(rsp_flags), 32'h0);

    // Flag passthrough from requester 1: FFFF + 0001
    req_op[1*OPSIZE +: OPSIZE] = 5'd0;
    req_a[1*DSIZE +: DSIZE] = 16'hFFFF;
    req_b[1*DSIZE +: DSIZE] = 16'h0001;
    step(1'b1, 4'b0010, 4'b0010, "flag_grant", 1'b0);
    step(1'b1, 4'b0000, 4'b0000, "flag_nogrant", 1'b1);
    step(1'b1, 4'b0000, 4'b0000, "flag_nogrant", 1'b1);
    #1;
    chk("flag_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("flag_rsp_id", 32'(rsp_id), 32'h1);
    chk("flag_rsp_f", 32'(rsp_f), 32'h0000);
    chk("flag_rsp_flags", 32'(rsp_flags), 32'hA);
    step(1'b1, 4'b0000, 4'b0000, "flag_nogrant", 1'b1);

    // Full contention from reset
    do_reset();
    for (int k = 0; k < 8; k++) begin
`ifdef FU_SCHED_PRIO_EN
      step(1'b1, 4'b1111, 4'b0001, "contention_grant", 1'b1);
`else
      step(1'b1, 4'b1111, 4'(4'b0001 << (k % 4)), "contention_grant", 1'b1);
`endif
    end
    repeat (3) step(1'b1, 4'b0000, 4'b0000, "contention_tail", 1'b1);

    // Table of per-cycle grant vectors from reset
    do_reset();
    for (int k = 0; k < 20; k++) begin
`ifdef FU_SCHED_PRIO_EN
      step(tbl[k].en, tbl[k].v, tbl[k].pr, $sformatf("table_%0d", k), 1'b1);
`else
      step(tbl[k].en, tbl[k].v, tbl[k].rr, $sformatf("table_%0d", k), 1'b1);
`endif
    end
    repeat (3) step(1'b1, 4'b0000, 4'b0000, "table_tail", 1'b1);
    chk("table_idle", 32'(idle), 32'h1);

    // Drain: three issues, then sched_en low with requests still valid
    do_reset();
`ifdef FU_SCHED_PRIO_EN
    repeat (3) step(1'b1, 4'b1111, 4'b0001, "drain_issue", 1'b1);
`else
    step(1'b1, 4'b1111, 4'b0001, "drain_issue", 1'b1);
    step(1'b1, 4'b1111, 4'b0010, "drain_issue", 1'b1);
    step(1'b1, 4'b1111, 4'b0100, "drain_issue", 1'b1);
`endif
    chk("drain_idle_e0", 32'(idle), 32'h0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 4'b1111, 4'b0000, "drain_no_grant", 1'b1);
      chk($sformatf("drain_idle_%0d", k + 1), 32'(idle), (k >= 2) ? 32'h1 : 32'h0);
    end
    chk("drain_all_rsp", 32'(sb.size()), 32'h0);

    // Reset one cycle after a handshake
    do_reset();
    step(1'b1, 4'b0010, 4'b0010, "midrst_grant", 1'b1);
    rst_n = 1'b0;
    sb.delete();
    req_valid = 4'b1111;
    #1;
    chk("midrst_req_ready", 32'(req_ready), 32'h0);
    chk("midrst_fu_a", 32'(fu_a), 32'h0);
    chk("midrst_fu_op", 32'(fu_op), 32'h0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("midrst_rsp_f", 32'(rsp_f), 32'h0);
    chk("midrst_idle", 32'(idle), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    last_gnt = '0; prev_v = '0;
    step(1'b1, 4'b1111, 4'b0001, "midrst_first_grant", 1'b1);
    repeat (4) step(1'b1, 4'b0000, 4'b0000, "midrst_tail", 1'b1);

`ifdef FU_SCHED_PRIO_EN
    // Requester 0 holds priority until it drops valid
    do_reset();
    repeat (3) step(1'b1, 4'b0011, 4'b0001, "prio_req0", 1'b1);
    step(1'b1, 4'b0010, 4'b0010, "prio_req1", 1'b1);
    repeat (3) step(1'b1, 4'b0000, 4'b0000, "prio_tail", 1'b1);
`endif

    chk("final_sb_empty", 32'(sb.size()), 32'h0);
    chk("final_idle", 32'(idle), 32'h1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fu_sched.md
# fu_sched

Round-robin scheduler that shares one `fu` functional unit (16-bit ALU with Z/N/C/V flags) among four requesters. Each requester offers an operation {op, a, b} over a valid/ready handshake. The scheduler issues at most one operation per cycle into the fu's registered inputs and tracks in-flight operations with a tag pipeline matched to the fu latency. It returns each result, tagged with the requester ID, on a shared response port. It sits between the requester logic and the `fu` instance.

## Interface
- DSIZE, 16, operand/result width
- OPSIZE, 5, fu opcode width
- FU_LAT, 1, edges from fu input update to stable F_o/flags (1..4)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- sched_en  in  1  1 = new issues allowed; 0 = in-flight operations drain, no new grants
- req_valid  in  4  per-requester request valid
- req_op  in  4*OPSIZE  packed opcodes; requester i at [i*OPSIZE +: OPSIZE]
- req_a  in  4*DSIZE  packed operand A, requester i at [i*DSIZE +: DSIZE]
- req_b  in  4*DSIZE  packed operand B, same packing
- req_ready  out  4  one-hot grant; handshake = req_valid[i] & req_ready[i] at a rising edge
- fu_op  out  OPSIZE  registered opcode to fu
- fu_a, fu_b  out  DSIZE  registered operands to fu
- fu_f  in  DSIZE  fu result F_o
- fu_z, fu_n, fu_c, fu_v  in  1  fu flags Z_o, N_o, C_o, V_o
- rsp_valid  out  1  one-cycle pulse per completed operation
- rsp_id  out  2  requester that issued the operation
- rsp_f  out  DSIZE  registered result
- rsp_flags  out  4  registered {Z,N,C,V}
- idle  out  1  no operation in flight and rsp_valid low

## Operation
- Arbitration is combinational from req_valid, sched_en, and the last-grant pointer `last[1:0]`. The search starts at last+1 and wraps 3→0. The first valid requester gets req_ready. req_ready is all-zero when sched_en=0 or no requester is valid.
- Requesters hold op/a/b stable while valid and not ready. A requester may drop valid without a handshake.
- On a handshake by requester i:
  - fu_op/fu_a/fu_b load requester i's fields.
  - last ← i.
  - Tag pipeline stage 0 ← {1, i}.
- Without a handshake, fu_op/fu_a/fu_b hold their values and stage 0 ← {0, x}.
- The tag pipeline has FU_LAT+1 stages of {vld, id[1:0]} and shifts every cycle. When the final stage is valid, rsp_f/rsp_flags capture fu_f and {fu_z,fu_n,fu_c,fu_v}, rsp_id ← the stage id, and rsp_valid=1.
- There is no response backpressure. Consumers must accept every rsp_valid pulse.
- idle = ~|{all tag stage vld bits, rsp_valid}.
- Reset values: req_ready 0, fu_op/fu_a/fu_b 0, rsp_valid 0, rsp_id 0, rsp_f 0, rsp_flags 0, idle 1, last = 3 (requester 0 wins first), all tag vld bits 0.
- Reset mid-operation: all in-flight tags are discarded, no response is produced for them, and arbitration restarts from requester 0.

## Timing
- Handshake at edge E: fu_* update at E. The fu result is stable after E+FU_LAT. rsp_* register at E+FU_LAT+1, and rsp_valid is high in the cycle after that edge.
- Handshake-to-response latency is FU_LAT+1 edges, i.e. 2 with the default FU_LAT=1.
- Throughput is one issue per cycle. Back-to-back issues give back-to-back rsp_valid pulses in issue order.
- If sched_en falls at edge E, no grant is made from E onward. Operations issued before E still complete, and idle rises FU_LAT+2 cycles after the last issue.
- All four requesters continuously valid gives grants in the order 0,1,2,3,0,… with one grant per cycle. Each requester waits at most 3 cycles.

## Configuration
- FU_SCHED_PRIO_EN defined: requester 0 has fixed top priority and is granted whenever it is valid and sched_en=1. Requesters 1..3 round-robin among themselves, and `last` tracks only those grants. Requesters 1..3 can starve while requester 0 stays valid.
- FU_SCHED_PRIO_EN undefined: pure 4-way round-robin as described above.

## Test plan
- Single request: after reset, req_valid=4'b0100 with op=0, a=16'h0003, b=16'h0004, and the fu stub computes F=a+b → req_ready=4'b0100 in the first cycle; rsp_valid 2 edges later with rsp_id=2, rsp_f=16'h0007, rsp_flags=4'b0000.
- Full contention: req_valid=4'b1111 held for 8 cycles → grant order 0,1,2,3,0,1,2,3; rsp_id sequence identical; 8 consecutive rsp_valid pulses.
- Flag passthrough: a=16'hFFFF, b=16'h0001 with the add stub (Z=1, C=1) → rsp_f=16'h0000, rsp_flags=4'b1010.
- Drain: issue on 3 consecutive cycles, then sched_en=0 with requests still valid → no further req_ready; 3 responses arrive; idle=1 afterwards.
- Reset mid-flight: rst_n low one cycle after a handshake → rsp_valid never pulses for that operation; all outputs take their reset values immediately; the first grant after release goes to requester 0.
- FU_SCHED_PRIO_EN defined, req_valid=4'b0011 → requester 0 is granted every cycle and requester 1 only after req_valid[0] drops.
